// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered round-robin stream mux.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

  // Successor of a channel index in a ring of n channels.
  function automatic int unsigned next_rr_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping N-1 -> 0.
// The pointer advances past the winner only when en_i confirms the grant was taken.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 2,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  output logic [SELW-1:0] grant_o,
  output logic            grant_vld_o
);

  logic [SELW-1:0] r_ptr;
  logic [SELW:0]   w_k;

  // ptr < N and offset < N, so one conditional subtract gives the modulo.
  always_comb begin
    grant_o     = '0;
    grant_vld_o = 1'b0;
    w_k         = '0;
    for (int i = 0; i < N; i++) begin
      w_k = {1'b0, r_ptr} + (SELW+1)'(i);
      if (w_k >= (SELW+1)'(N)) w_k = w_k - (SELW+1)'(N);
      if (!grant_vld_o && req_i[w_k[SELW-1:0]]) begin
        grant_o     = w_k[SELW-1:0];
        grant_vld_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (en_i && grant_vld_o) begin
      r_ptr <= SELW'(next_rr_ptr(int'(grant_o), N));
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with fixed-select or round-robin grant and one output register.
// One cycle latency, full throughput; a stalled output register blocks every input.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 2,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mode_i,
  input  logic [SELW-1:0] sel_i,
  input  logic [N*W-1:0]  in_data_i,
  input  logic [N-1:0]    in_valid_i,
  output logic [N-1:0]    in_ready_o,
  output logic [W-1:0]    out_data_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [SELW-1:0] out_ch_o
);

  logic [W-1:0]    r_dat;
  logic            r_vld;
  logic [SELW-1:0] r_ch;

  mux_mode_e       w_mode;
  logic            w_load_en;
  logic [SELW-1:0] w_gnt;
  logic            w_gnt_vld;
  logic [SELW-1:0] w_arb_gnt;
  logic            w_arb_vld;
  logic            w_xfer;

  assign w_mode    = mux_mode_e'(mode_i);
  assign w_load_en = !r_vld || out_ready_i;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (in_valid_i),
    .en_i        (w_xfer && (w_mode == MUX_RR)),
    .grant_o     (w_arb_gnt),
    .grant_vld_o (w_arb_vld)
  );

  // sel_i can name a channel that does not exist when N is not a power of two.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    if (w_mode == MUX_FIXED) begin
      w_gnt     = sel_i;
      w_gnt_vld = (int'(sel_i) < N);
    end else begin
      w_gnt     = w_arb_gnt;
      w_gnt_vld = w_arb_vld;
    end
  end

  always_comb begin
    in_ready_o = '0;
    if (rst_ni && w_gnt_vld && w_load_en) in_ready_o[w_gnt] = 1'b1;
  end

  assign w_xfer = |(in_valid_i & in_ready_o);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_ch  <= '0;
    end else if (w_xfer) begin
      r_vld <= 1'b1;
      r_dat <= in_data_i[w_gnt*W +: W];
      r_ch  <= w_gnt;
    end else if (out_ready_i) begin
      r_vld <= 1'b0;
    end
  end

  assign out_data_o  = r_dat;
  assign out_valid_o = r_vld;
  assign out_ch_o    = r_ch;

endmodule
